// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the register interface / UART transmitter and the TX FIFO.
// The master side is the environment (CPU writes plus transmitter busy); the slave side is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH        = 4,
    parameter int PAYLOAD_BITS = 8
);
    logic                    wr_en;
    logic [PAYLOAD_BITS-1:0] wr_data;
    logic                    flush;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;
    logic                    idle;
    logic                    tx_en;
    logic [PAYLOAD_BITS-1:0] tx_data;
    logic                    tx_busy;

    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  full, count, idle, tx_en, tx_data
    );

    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output full, count, idle, tx_en, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular TX FIFO feeding a UART transmitter through a one-cycle en strobe.
// The FSM hands over one entry per transmitter busy-low period.
module uart_tx_fifo #(
    parameter int DEPTH        = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input logic            clk,
    input logic            rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    ptr_t                    rd_ptr_q, rd_ptr_d;
    ptr_t                    wr_ptr_q, wr_ptr_d;
    cnt_t                    count_q, count_d;
    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [PAYLOAD_BITS-1:0] mem_d [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    always_comb begin
        fifo_full  = (count_q == cnt_t'(DEPTH));
        fifo_empty = (count_q == '0);
        pop        = (state_q == S_ISSUE);
        push       = bus.wr_en && !fifo_full && !bus.flush;
    end

    // A flush in IDLE must not launch an ISSUE of an entry that is being discarded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty && !bus.tx_busy && !bus.flush) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (!bus.tx_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.wr_data;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
            if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.full    = fifo_full;
    assign bus.count   = count_q;
    assign bus.tx_en   = (state_q == S_ISSUE);
    assign bus.tx_data = mem_q[rd_ptr_q];
    assign bus.idle    = fifo_empty && (state_q == S_IDLE) && !bus.tx_busy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter that stays busy busy_len cycles.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int PB    = 8;
    typedef logic [$clog2(DEPTH):0] cnt_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH), .PAYLOAD_BITS(PB)) bus ();
    uart_tx_fifo #(.DEPTH(DEPTH), .PAYLOAD_BITS(PB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   cyc       = 0;
    int   busy_cnt  = 0;
    int   busy_len  = 20;
    logic hold_busy = 1'b0;
    int   n_cmp     = 0;
    int   n_err     = 0;

    logic [PB-1:0] exp_q[$];
    logic [PB-1:0] got_q[$];
    int            got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter accepts en only while idle; busy rises next cycle.
    always @(posedge clk) begin
        if (bus.tx_en && !bus.tx_busy) busy_cnt <= busy_len;
        else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = hold_busy || (busy_cnt > 0);

    always @(negedge clk) begin
        if (bus.tx_en === 1'b1) begin
            got_q.push_back(bus.tx_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [PB-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.wr_en = 1'b0; bus.flush = 1'b0; bus.wr_data = '0; hold_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", bus.full); end
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_err++; $display("FAIL reset_tx_en got %b exp 0", bus.tx_en); end
        n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b exp 1", bus.idle); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.tx_en !== 1'b0) begin n_err++; $display("FAIL reset_hold_tx_en cyc %0d got %b exp 0", i, bus.tx_en); end
        end
    endtask

    task automatic test_single();
        int c0;
        clear_sb();
        busy_len = 20;
        tick();
        c0 = cyc;
        write_byte(8'hA5);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 10 && got_q.size() == 0; i++) tick();
        n_cmp++;
        if (got_q.size() == 0) begin
            n_err++; $display("FAIL single_timeout got 0 strobes exp 1");
        end else begin
            if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL single_data got %h exp %h", got_q[0], exp_q[0]); end
            void'(exp_q.pop_front());
            n_cmp++; if (got_cyc[0] != c0 + 2) begin n_err++; $display("FAIL single_latency got %0d exp %0d", got_cyc[0] - c0, 2); end
        end
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL single_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_err++; $display("FAIL single_one_pulse got %b exp 0", bus.tx_en); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.tx_busy) break;
        end
        n_cmp++; if (bus.tx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy_timeout got %b exp 0", bus.tx_busy); end
        n_cmp++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL single_idle_in_wait got %b exp 0", bus.idle); end
        @(negedge clk);
        n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL single_idle_after got %b exp 1", bus.idle); end
    endtask

    task automatic test_full();
        logic [PB-1:0] d5 [5];
        int exp_cnt;
        d5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_sb();
        hold_busy = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = d5[k];
            tick();
            if (k < DEPTH) exp_q.push_back(d5[k]);
            exp_cnt = (k + 1 > DEPTH) ? DEPTH : k + 1;
            n_cmp++; if (bus.count !== cnt_t'(exp_cnt)) begin n_err++; $display("FAIL full_count w%0d got %0d exp %0d", k, bus.count, exp_cnt); end
            n_cmp++; if (bus.full !== (k >= DEPTH - 1)) begin n_err++; $display("FAIL full_flag w%0d got %b exp %b", k, bus.full, k >= DEPTH - 1); end
        end
        bus.wr_en = 1'b0;
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_err++; $display("FAIL full_no_issue_busy got %b exp 0", bus.tx_en); end
        busy_len = 10;
        hold_busy = 1'b0;
        for (int i = 0; i < 200 && got_q.size() < 4; i++) tick();
        for (int i = 0; i < 40 && !bus.idle; i++) tick();
        n_cmp++;
        if (got_q.size() != 4) begin
            n_err++; $display("FAIL full_strobes got %0d exp 4", got_q.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (j > 0) n_cmp++;
                if (got_q[j] !== exp_q[0]) begin n_err++; $display("FAIL full_order idx %0d got %h exp %h", j, got_q[j], exp_q[0]); end
                void'(exp_q.pop_front());
            end
            for (int j = 1; j < 4; j++) begin
                n_cmp++;
                if (got_cyc[j] - got_cyc[j-1] != busy_len + 3) begin
                    n_err++; $display("FAIL full_gap idx %0d got %0d exp %0d", j, got_cyc[j] - got_cyc[j-1], busy_len + 3);
                end
            end
        end
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL full_drain_count got %0d exp 0", bus.count); end
    endtask

    task automatic wait_issue(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.tx_en === 1'b1) begin found = 1'b1; break; end
        end
    endtask

    task automatic test_simul();
        bit found;
        clear_sb();
        hold_busy = 1'b1; busy_len = 6;
        tick();
        write_byte(8'h01); exp_q.push_back(8'h01);
        write_byte(8'h02); exp_q.push_back(8'h02);
        hold_busy = 1'b0;
        wait_issue(found);
        n_cmp++; if (!found) begin n_err++; $display("FAIL simul_issue_timeout got 0 exp 1"); end
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        bus.wr_en = 1'b0;
        exp_q.push_back(8'h77);
        n_cmp++; if (bus.count !== cnt_t'(2)) begin n_err++; $display("FAIL simul_count got %0d exp 2", bus.count); end
        for (int i = 0; i < 100 && got_q.size() < 3; i++) tick();
        for (int i = 0; i < 40 && !bus.idle; i++) tick();
        n_cmp++;
        if (got_q.size() != 3) begin
            n_err++; $display("FAIL simul_strobes got %0d exp 3", got_q.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (j > 0) n_cmp++;
                if (got_q[j] !== exp_q[0]) begin n_err++; $display("FAIL simul_order idx %0d got %h exp %h", j, got_q[j], exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL simul_drain_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_flush();
        bit found;
        clear_sb();
        hold_busy = 1'b1; busy_len = 6;
        tick();
        write_byte(8'hC1); write_byte(8'hC2); write_byte(8'hC3);
        hold_busy = 1'b0;
        wait_issue(found);
        n_cmp++; if (!found) begin n_err++; $display("FAIL flush_issue_timeout got 0 exp 1"); end
        exp_q.push_back(8'hC1);
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h99;
        tick();
        bus.flush = 1'b0; bus.wr_en = 1'b0;
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL flush_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL flush_full got %b exp 0", bus.full); end
        for (int i = 0; i < 40; i++) tick();
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL flush_strobes got %0d exp 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL flush_head got %h exp %h", got_q[0], exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL flush_idle got %b exp 1", bus.idle); end
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL flush_end_count got %0d exp 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_sb();
        hold_busy = 1'b1; busy_len = 10;
        tick();
        write_byte(8'hD1); write_byte(8'hD2); write_byte(8'hD3);
        hold_busy = 1'b0;
        wait_issue(found);
        n_cmp++; if (!found) begin n_err++; $display("FAIL rstmid_issue_timeout got 0 exp 1"); end
        exp_q.push_back(8'hD1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.count !== cnt_t'(0)) begin n_err++; $display("FAIL rstmid_count got %0d exp 0", bus.count); end
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_en got %b exp 0", bus.tx_en); end
        n_cmp++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_while_busy got %b exp 0", bus.idle); end
        for (int i = 0; i < 40; i++) tick();
        n_cmp++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL rstmid_strobes got %0d exp 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL rstmid_head got %h exp %h", got_q[0], exp_q[0]); end
            void'(exp_q.pop_front());
        end
        n_cmp++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL rstmid_idle_end got %b exp 1", bus.idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts bytes from the peripheral register interface into a small circular FIFO and feeds them one at a time to the transmitter's en/data/busy handshake. The CPU can queue several bytes without polling busy per character. It also reports fill level and an all-done indication for status registers and interrupts.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PAYLOAD_BITS, 8, data bits per entry; must match the transmitter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  PAYLOAD_BITS  byte to queue
flush  input  1  discard all queued (not yet issued) entries
full  output  1  count == DEPTH
count  output  $clog2(DEPTH)+1  number of queued entries
idle  output  1  FIFO empty, FSM in IDLE and tx_busy low
tx_en  output  1  one-cycle send strobe to the transmitter
tx_data  output  PAYLOAD_BITS  head-of-FIFO entry, valid while tx_en=1
tx_busy  input  1  transmitter busy

Behaviour:
- One clock domain, clk. rst is synchronous active-high and overrides every other input.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, full=0, tx_en=0, FSM=IDLE. idle=1 provided tx_busy=0. tx_data is don't-care outside tx_en.
- Storage: DEPTH x PAYLOAD_BITS register array. Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. No reset is applied to the array.
- tx_data is driven combinationally as mem[rd_ptr].
- Transmitter contract: it samples data when tx_en=1 while it is idle, and raises tx_busy on the next cycle. tx_busy stays high until the stop bit has been sent.
- FSM states:
  - IDLE: if count!=0 and tx_busy=0, go to ISSUE; otherwise stay.
  - ISSUE: tx_en=1 for exactly this cycle. Pop the FIFO (rd_ptr+1, count-1). Go to WAIT unconditionally.
  - WAIT: tx_en=0. When tx_busy=0, go to IDLE. The first WAIT cycle always sees tx_busy=1 under the contract above.
- tx_en is a registered-state decode (state==ISSUE). It is never high on two consecutive cycles.
- Latency:
  - wr_en at cycle N into an empty FIFO with the transmitter idle: IDLE sees count=1 at N+1, tx_en=1 at N+2.
  - No combinational bypass from wr_data to tx_data.
- Gap between characters: after tx_busy falls, IDLE lasts one cycle before the next ISSUE.
- Write rules:
  - wr_en with count<DEPTH: store at wr_ptr, wr_ptr+1.
  - wr_en with count==DEPTH is silently dropped, even if a pop occurs the same cycle. There is no overflow flag.
- Simultaneous push and pop (wr_en accepted during ISSUE): count unchanged, both pointers advance.
- Flush:
  - Next cycle, rd_ptr=wr_ptr=0 and count=0. Flush has priority over a same-cycle wr_en, which is dropped.
  - Flush does not abort a character already handed over. If asserted during ISSUE, tx_en still pulses that cycle with the current head, and the FSM proceeds to WAIT.
- Reset mid-operation: everything returns to reset values next cycle. An in-flight tx_en pulse ends. Queued data is lost.
- full and count are decoded from the count register. idle is combinational: (count==0) && state==IDLE && !tx_busy.

Test Plan:
- Reset with tx_busy=0 -> count=0, full=0, tx_en=0, idle=1. Hold 5 cycles; tx_en stays 0.
- Write 0xA5 at cycle N; model transmitter raises busy for 20 cycles -> tx_en=1 only at N+2 with tx_data=0xA5. count returns to 0. idle=1 the cycle after busy falls.
- Write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles while tx_busy is held high -> full=1 after the 4th write, count=4, 0x55 dropped. Then release busy per character -> bytes emitted in order 0x11,0x22,0x33,0x44, one tx_en per busy-low period.
- Pre-load 2 bytes, then assert wr_en=0x77 in the ISSUE cycle -> count stays 2, with no loss or duplication. Output order is preserved, including pointer wrap after 5+ total writes with DEPTH=4.
- Queue 3 bytes, and assert flush coincident with the first ISSUE plus wr_en=0x99 -> the first byte is still sent. count=0 next cycle, 0x99 dropped, no further tx_en.
- Queue 3 bytes, and pulse rst during WAIT -> count=0, FSM=IDLE, and no tx_en afterwards even when tx_busy falls.
